// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_t;

  function automatic int unsigned clog2(int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/RCA16bit.sv
// 16-bit ripple-carry adder datapath; purely combinational.
module RCA16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[16];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one 16-bit word per clock, LSW first, carry
// registered between words.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                    cout,
  output logic                    overflow,
  output logic                    done_valid,
  input  logic                    done_ready
);

  localparam int unsigned N  = WORD_W * WORDS;
  localparam int unsigned CW = clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  mp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic [N-1:0]  a_q, bc_q, result_q;
  logic          cout_q, ovf_q;

  logic [WORD_W-1:0] a_word, b_word, sum_word;
  logic              add_cout;
  logic              accept, last;

  assign accept = (state_q == IDLE) && start_valid;
  assign last   = (cnt_q == LAST);

  assign a_word = a_q[cnt_q*WORD_W +: WORD_W];
  assign b_word = bc_q[cnt_q*WORD_W +: WORD_W];

  RCA16bit u_rca (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .sum  (sum_word),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      bc_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        bc_q    <= sub ? ~b : b;
        // Subtract is A + ~B + 1, so the initial carry supplies the +1.
        carry_q <= sub ? 1'b1 : cin;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        result_q[cnt_q*WORD_W +: WORD_W] <= sum_word;
        carry_q <= add_cout;
        cnt_q   <= cnt_q + 1'b1;
        if (last) begin
          cout_q <= add_cout;
          ovf_q  <= (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
                    (sum_word[WORD_W-1] != a_word[WORD_W-1]);
        end
      end
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4): directed table, random ops
// against a signed/unsigned arithmetic model, backpressure and reset mid-run.
module tb_mp_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned N = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid, start_ready;
  logic [N-1:0] a, b, result;
  logic         cin, sub, cout, overflow, done_valid, done_ready;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  typedef struct {
    string        name;
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [N-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: unsigned sum for result/cout, exact signed arithmetic for overflow.
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mcin,
                       input logic msub, output logic [N-1:0] mres, output logic mco,
                       output logic mov);
    logic [N:0]          us;
    logic signed [N+1:0] sa, sb, st, sr;
    if (msub) us = {1'b0, ma} + {1'b0, ~mb} + (N+1)'(1);
    else      us = {1'b0, ma} + {1'b0, mb} + (N+1)'(mcin);
    mres = us[N-1:0];
    mco  = us[N];
    sa = {{2{ma[N-1]}}, ma};
    sb = {{2{mb[N-1]}}, mb};
    st = msub ? (sa - sb) : (sa + sb + (N+2)'(mcin));
    sr = {{2{mres[N-1]}}, mres};
    mov = (st != sr);
  endtask

  task automatic run_op(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic vcin, input logic vsub, input logic [N-1:0] eres,
                        input logic eco, input logic eov, input int hold);
    int lat;
    int t;
    t = 0;
    while (!start_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk({name, " start_ready"}, 64'(start_ready), 64'd1);
    a = va; b = vb; cin = vcin; sub = vsub; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!done_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(WORDS));
    chk({name, " result"}, result, eres);
    chk({name, " cout"}, 64'(cout), 64'(eco));
    chk({name, " overflow"}, 64'(overflow), 64'(eov));
    for (int h = 0; h < hold; h++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; start_valid = ~start_valid;
      @(posedge clk); #1;
      chk({name, " hold result"}, result, eres);
      chk({name, " hold flags"}, {62'd0, cout, overflow}, {62'd0, eco, eov});
      chk({name, " hold done_valid"}, 64'(done_valid), 64'd1);
      chk({name, " hold start_ready"}, 64'(start_ready), 64'd0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk({name, " idle start_ready"}, 64'(start_ready), 64'd1);
    chk({name, " idle done_valid"}, 64'(done_valid), 64'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, " start_ready"}, 64'(start_ready), 64'd1);
    chk({name, " done_valid"}, 64'(done_valid), 64'd0);
    chk({name, " result"}, result, 64'd0);
    chk({name, " flags"}, {62'd0, cout, overflow}, 64'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, er;
    logic         rc, rs, eco, eov;

    tbl[0] = '{"small_add", 64'h8, 64'h2, 1'b0, 1'b0, 64'hA, 1'b0, 1'b0};
    tbl[1] = '{"word_carry", 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0};
    tbl[2] = '{"word_carry_cin", 64'hFFFF, 64'h1, 1'b1, 1'b0, 64'h1_0001, 1'b0, 1'b0};
    tbl[3] = '{"full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[4] = '{"sub_neg", 64'h48, 64'h49, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[5] = '{"add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[6] = '{"sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("reset");

    foreach (tbl[i])
      run_op(tbl[i].name, tbl[i].va, tbl[i].vb, tbl[i].vcin, tbl[i].vsub,
             tbl[i].res, tbl[i].co, tbl[i].ov, 0);

    // Backpressure: done held for 3 cycles while inputs toggle.
    run_op("backpressure", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
           64'h2222_2222_2222_2212, 1'b0, 1'b0, 3);

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) rb = ~ra;
      rc = 1'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rc, rs, er, eco, eov);
      run_op("random", ra, rb, rc, rs, er, eco, eov, $urandom_range(0, 2));
    end

    // Reset after word 1 is registered, with a carry in flight.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("mid_run_reset");
    run_op("after_reset", 64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add/subtract sequencer that computes WORDS×16-bit sums by time-multiplexing one 16-bit ripple-carry adder, one word per clock, least-significant word first, with the carry registered between words. It sits between a requester using a valid/ready handshake and the existing `RCA16bit` datapath. It owns operand capture, word sequencing, subtract conditioning, result assembly and flag generation.

## Interface
- `WORDS`, default 4: number of 16-bit words per operand; legal range 2..16; operand width is N = 16×WORDS.
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  request present.
- `start_ready`  out  1  block can accept a request; high only in IDLE.
- `a`  in  N  operand A; sampled only on the accept edge.
- `b`  in  N  operand B; sampled only on the accept edge.
- `cin`  in  1  carry-in for add; ignored when `sub`=1.
- `sub`  in  1  0 computes A+B+cin; 1 computes A−B as A+~B+1.
- `result`  out  N  sum or difference; valid while `done_valid`=1.
- `cout`  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- `overflow`  out  1  two's-complement signed overflow of the N-bit operation.
- `done_valid`  out  1  result available.
- `done_ready`  in  1  consumer accepts the result.

## Operation
- Accept: a request is accepted on an edge where `start_valid`=1 and `start_ready`=1.
  - On accept, latch `a`, the conditioned B (`b` or `~b`), and the initial carry (`cin`, or 1 when `sub`=1).
  - Clear the word counter and go to RUN.
- RUN:
  - Each cycle, feed word k of A, conditioned-B word k and the carry register to `RCA16bit`.
  - Register the 16-bit sum into `result[16k+15:16k]` and register the adder `cout` as the next carry.
  - Increment k.
  - When k = WORDS−1 on this edge, also load `cout` and `overflow`, then go to DONE.
- Overflow is captured from the top word: `overflow = (A[N−1] == Bc[N−1]) && (sum[N−1] != A[N−1])`, where Bc is conditioned B.
- DONE:
  - `done_valid`=1.
  - `result`, `cout` and `overflow` are held stable until accepted.
  - On an edge with `done_ready`=1, go to IDLE.
- No request is accepted in the same cycle as a DONE→IDLE transition; `start_ready` rises the cycle after.
- Changes on `a`, `b`, `cin`, `sub` or `start_valid` while in RUN or DONE have no effect.
- State encoding: IDLE, RUN, DONE. Any unused encoding goes to IDLE.
- Reset (from any state, including mid-RUN):
  - Next cycle: state IDLE, `start_ready`=1.
  - `done_valid`=0, `result`=0, `cout`=0, `overflow`=0.
  - Counter and carry cleared; any in-flight operation is discarded.

## Timing
- Accept edge = edge 0. Words 0..WORDS−1 are registered on edges 1..WORDS.
- `done_valid` is high in the cycle following edge WORDS. Latency is WORDS cycles, accept to `done_valid`.
- Throughput: at most one operation per WORDS+2 cycles (accept cycle, WORDS RUN cycles, DONE cycle with immediate `done_ready`).
- `start_ready` is low from the cycle after accept until the cycle after the DONE handshake.
- Critical path: carry register → 16-bit ripple chain → result/carry registers. No path crosses words combinationally.

## Structure
- Package `mp_add_pkg` holds:
  - `WORD_W` = 16.
  - State typedef `mp_state_t` {IDLE, RUN, DONE}.
  - Counter width function `clog2(WORDS)`.
- Single sub-module: one `RCA16bit` instance, used purely combinationally.
- Everything else (operand registers, word mux, result demux, carry register, FSM) lives in `mp_add_seq`.

## Test plan
All scenarios use WORDS=4.
1. Small add: A=0x0000_0000_0000_0008, B=0x0000_0000_0000_0002, cin=0, sub=0 → result 0x0000_0000_0000_000A, cout=0, overflow=0. `done_valid` rises exactly 4 cycles after the accept edge.
2. Inter-word carry: A=0x0000_0000_0000_FFFF, B=0x0000_0000_0000_0001 → result 0x0000_0000_0001_0000, cout=0. Same operands with cin=1 → 0x0000_0000_0001_0001.
3. Full wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 → result 0, cout=1, overflow=0.
4. Subtract and signed overflow:
   - A=0x48, B=0x49, sub=1 → result 0xFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0.
   - A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, sub=0 → result 0x8000_0000_0000_0000, overflow=1.
5. Backpressure: hold `done_ready`=0 for 3 cycles while toggling `a`, `b` and `start_valid` → `result`/flags stable, `start_ready`=0. Raise `done_ready` → IDLE next cycle, `start_ready`=1.
6. Reset mid-RUN: assert `rst` after word 1 is registered → next cycle all outputs 0 and `start_ready`=1. A new request then completes with the correct result, with no leftover carry.
